fwd_scoreboard: RTL and testbench
=================================

Name: fwd_scoreboard

Overview:
- Parametrised hazard-detection and forwarding unit for the 5-stage MIPS pipeline.
- Replaces the fixed EXE/MEM address-compare logic in the pipeline controller with a per-register scoreboard.
- Each entry tracks pipeline age and result latency, so variable-latency producers are supported (ALU=1, load=2, multi-cycle mul/div up to MAX_LAT).
- Produces the ID-stage load-use/latency stall, per-operand forwarding selects, a late-store-data forward flag and a stall-cycle counter.

Parameters:
- NREG, 32, architectural register count (register 0 is hard-wired zero).
- AW, 5, register address width; AW = clog2(NREG).
- FWD_DEPTH, 2, number of forwarding taps beyond ID (1=EXE, 2=MEM). Older results come from the write-through regfile.
- LW, 3, width of the latency/age fields; 2**LW-1 >= MAX_LAT.
- MAX_LAT, 6, largest legal dst_lat.
- CW, 16, stall counter width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- en  in  1  pipeline advance. 0 freezes all state (debug/step).
- id_valid  in  1  ID holds a real instruction
- rs_addr  in  AW  source A address
- rs_used  in  1  source A read by instruction
- rt_addr  in  AW  source B address
- rt_used  in  1  source B read by instruction
- rt_late  in  1  rt needed one stage later (store data consumed in MEM)
- dst_addr  in  AW  destination register
- dst_wen  in  1  instruction writes dst_addr
- dst_lat  in  LW  cycles from EXE entry until result is forwardable
- stall  out  1  hold IF/ID, insert bubble into EXE
- fwd_a  out  LW  0 = regfile, k = forward from stage age k
- fwd_b  out  LW  as fwd_a, for rt
- fwd_b_late  out  1  fwd_b refers to the late (MEM-stage) store-data path
- stall_count  out  CW  cycles with stall=1 and en=1

Behaviour:
- State: per register r in 1..NREG-1: busy[r], age[r] (LW), lat[r] (LW). Register 0 is never tracked; a dst_addr of 0 is ignored.
- Reset (clk edge with rst=1): all busy=0, stall_count=0. While rst=1: stall=0, fwd_a=fwd_b=0, fwd_b_late=0.
- Combinational lookup per source s (rs, rt), with hit = used && addr!=0 && busy[addr]:
  - eff_age = age + 1 for rt when rt_late=1; otherwise eff_age = age.
  - ready = eff_age >= lat.
  - hit && !ready -> operand stalls.
  - hit && ready -> fwd = age (the producer's physical stage). fwd_b_late = rt_late && age < lat.
  - no hit -> fwd = 0.
  - stall = id_valid && (rs stalls || rt stalls).
- Issue: issue = en && id_valid && !stall && dst_wen && dst_addr!=0.
- Update on each edge with en=1:
  - Every busy entry: age++. An entry with age == FWD_DEPTH clears busy instead (its result is now in the regfile).
  - Then, if issue: entry[dst_addr] <= busy=1, age=1, lat=max(dst_lat,1).
  - Issue wins over a same-cycle retire or age update of the same register (WAW: the youngest producer owns the entry).
- en=0: no state change and no issue; outputs still reflect current state.
- dst_lat > FWD_DEPTH: consumers stall until the entry retires, then read the regfile (fwd=0).
- rs_addr == rt_addr: both operands are evaluated independently with identical results, except where rt_late differs.
- stall_count increments when en && stall, and saturates at all-ones.
- Latency: issue-to-visible is 1 cycle. A producer issued at edge n has age 1 at cycle n+1.
- Ages are clamped so there is no wrap; age never exceeds FWD_DEPTH.

Decomposition:
- Shared package mips_define (extend it): FWD_RF=0, FWD_EXE=1, FWD_MEM=2; LAT_ALU=1, LAT_LOAD=2, LAT_MULDIV default.
- One sub-module, fwd_lookup: combinational single-operand hit/ready/fwd evaluation, instantiated for rs and for rt. Its late input is tied 0 for rs.
- The entry array and counter stay in the top module.

Test Plan:
- ALU add $3 issued (lat 1), next cycle sub reads rs=$3 -> stall=0, fwd_a=1. One cycle later another reader of $3 -> fwd_a=2. Third cycle -> fwd_a=0.
- lw $4 (lat 2), next instruction add rs=$4 -> stall=1 for exactly 1 cycle, then fwd_a=2; stall_count=1.
- lw $5, next instruction sw with rt=$5, rt_late=1 -> stall=0, fwd_b=1, fwd_b_late=1.
- mul $6 with dst_lat=4, FWD_DEPTH=2, immediate reader of $6 -> stall for 2 cycles, then fwd_a=0; stall_count=2.
- WAW: addi $7 (lat 1) then lw $7 (lat 2) back to back, then reader of $7 -> stall 1 cycle (tracks the lw), then fwd_a=2.
- en=0 for 3 cycles mid-hazard -> stall, fwd values and ages are frozen. Writes to $0 never stall a reader of $0. rst mid-hazard -> all outputs 0 next cycle.

Source files
------------

// File: rtl/mips_define.sv
// rtl/mips_define.sv - shared pipeline constants: forwarding taps and producer latencies
package mips_define;

    // Forwarding select encoding: 0 reads the regfile, k forwards from stage age k
    localparam int FWD_RF  = 0;
    localparam int FWD_EXE = 1;
    localparam int FWD_MEM = 2;

    // Cycles from EXE entry until a producer's result can be forwarded
    localparam int LAT_ALU    = 1;
    localparam int LAT_LOAD   = 2;
    localparam int LAT_MULDIV = 4;

endpackage

// File: rtl/fwd_lookup.sv
// rtl/fwd_lookup.sv - single-operand scoreboard hit/ready/forward evaluation
module fwd_lookup
    import mips_define::*;
#(
    parameter int AW = 5,
    parameter int LW = 3
) (
    input  logic          used,
    input  logic [AW-1:0] addr,
    input  logic          busy,
    input  logic [LW-1:0] age,
    input  logic [LW-1:0] lat,
    input  logic          late,
    output logic          stall_op,
    output logic [LW-1:0] fwd,
    output logic          fwd_late
);

    logic          hit;
    logic [LW:0]   eff_age;
    logic          ready;

    // A late consumer (store data read in MEM) gains one extra cycle of producer progress
    always_comb begin
        hit      = used && (addr != '0) && busy;
        eff_age  = {1'b0, age} + {{LW{1'b0}}, late};
        ready    = eff_age >= {1'b0, lat};
        stall_op = 1'b0;
        fwd      = LW'(FWD_RF);
        fwd_late = 1'b0;
        if (hit) begin
            if (!ready) begin
                stall_op = 1'b1;
            end else begin
                fwd      = age;
                fwd_late = late && (age < lat);
            end
        end
    end

endmodule

// File: rtl/fwd_scoreboard.sv
// rtl/fwd_scoreboard.sv - per-register scoreboard for hazard stall and forwarding selects
module fwd_scoreboard
    import mips_define::*;
#(
    parameter int NREG      = 32,
    parameter int AW        = 5,
    parameter int FWD_DEPTH = FWD_MEM,
    parameter int LW        = 3,
    parameter int MAX_LAT   = 6,
    parameter int CW        = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          id_valid,
    input  logic [AW-1:0] rs_addr,
    input  logic          rs_used,
    input  logic [AW-1:0] rt_addr,
    input  logic          rt_used,
    input  logic          rt_late,
    input  logic [AW-1:0] dst_addr,
    input  logic          dst_wen,
    input  logic [LW-1:0] dst_lat,
    output logic          stall,
    output logic [LW-1:0] fwd_a,
    output logic [LW-1:0] fwd_b,
    output logic          fwd_b_late,
    output logic [CW-1:0] stall_count
);

    logic [NREG-1:0] busy_q;
    logic [LW-1:0]   age_q [NREG];
    logic [LW-1:0]   lat_q [NREG];

    logic            rs_stall;
    logic            rt_stall;
    logic [LW-1:0]   rs_fwd;
    logic [LW-1:0]   rt_fwd;
    logic            rs_fwd_late;
    logic            rt_fwd_late;
    logic            stall_raw;
    logic            issue;
    logic [LW-1:0]   issue_lat;

    fwd_lookup #(.AW(AW), .LW(LW)) u_rs_lookup (
        .used     (rs_used),
        .addr     (rs_addr),
        .busy     (busy_q[rs_addr]),
        .age      (age_q[rs_addr]),
        .lat      (lat_q[rs_addr]),
        .late     (1'b0),
        .stall_op (rs_stall),
        .fwd      (rs_fwd),
        .fwd_late (rs_fwd_late)
    );

    fwd_lookup #(.AW(AW), .LW(LW)) u_rt_lookup (
        .used     (rt_used),
        .addr     (rt_addr),
        .busy     (busy_q[rt_addr]),
        .age      (age_q[rt_addr]),
        .lat      (lat_q[rt_addr]),
        .late     (rt_late),
        .stall_op (rt_stall),
        .fwd      (rt_fwd),
        .fwd_late (rt_fwd_late)
    );

    // Stall/issue decision and outputs; reset forces outputs quiet
    always_comb begin
        stall_raw  = id_valid && (rs_stall || rt_stall);
        issue      = en && id_valid && !stall_raw && dst_wen && (dst_addr != '0);
        stall      = !rst && stall_raw;
        fwd_a      = rst ? '0 : rs_fwd;
        fwd_b      = rst ? '0 : rt_fwd;
        fwd_b_late = !rst && rt_fwd_late;
    end

    // Zero latency still means one cycle in EXE; out-of-range latencies clamp to the max
    always_comb begin
        issue_lat = dst_lat;
        if (dst_lat == '0) begin
            issue_lat = LW'(LAT_ALU);
        end else if (dst_lat > LW'(MAX_LAT)) begin
            issue_lat = LW'(MAX_LAT);
        end
    end

    // Entry array: age busy producers, retire past the last tap, youngest issue owns the entry
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                busy_q[r] <= 1'b0;
                age_q[r]  <= '0;
                lat_q[r]  <= '0;
            end
        end else if (en) begin
            busy_q[0] <= 1'b0;
            for (int r = 1; r < NREG; r++) begin
                if (busy_q[r]) begin
                    if (age_q[r] >= LW'(FWD_DEPTH)) begin
                        busy_q[r] <= 1'b0;
                    end else begin
                        age_q[r] <= age_q[r] + 1'b1;
                    end
                end
                if (issue && (dst_addr == AW'(r))) begin
                    busy_q[r] <= 1'b1;
                    age_q[r]  <= LW'(FWD_EXE);
                    lat_q[r]  <= issue_lat;
                end
            end
        end
    end

    // Saturating count of advancing cycles lost to stalls
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (en && stall_raw && (stall_count != '1)) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_fwd_scoreboard.sv
// tb/tb_fwd_scoreboard.sv - self-checking bench for fwd_scoreboard
module tb_fwd_scoreboard;
    import mips_define::*;

    localparam int NREG      = 32;
    localparam int AW        = 5;
    localparam int FWD_DEPTH = 2;
    localparam int LW        = 3;
    localparam int MAX_LAT   = 6;
    localparam int CW        = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          en;
    logic          id_valid;
    logic [AW-1:0] rs_addr;
    logic          rs_used;
    logic [AW-1:0] rt_addr;
    logic          rt_used;
    logic          rt_late;
    logic [AW-1:0] dst_addr;
    logic          dst_wen;
    logic [LW-1:0] dst_lat;
    logic          stall;
    logic [LW-1:0] fwd_a;
    logic [LW-1:0] fwd_b;
    logic          fwd_b_late;
    logic [CW-1:0] stall_count;

    int tests = 0;
    int fails = 0;

    fwd_scoreboard #(
        .NREG(NREG), .AW(AW), .FWD_DEPTH(FWD_DEPTH), .LW(LW), .MAX_LAT(MAX_LAT), .CW(CW)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .id_valid(id_valid),
        .rs_addr(rs_addr), .rs_used(rs_used), .rt_addr(rt_addr), .rt_used(rt_used),
        .rt_late(rt_late), .dst_addr(dst_addr), .dst_wen(dst_wen), .dst_lat(dst_lat),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b), .fwd_b_late(fwd_b_late),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    // Model: list of in-flight producers, each with the number of advancing edges since issue
    int q_reg[$];
    int q_lat[$];
    int q_adv[$];
    int m_cnt;
    bit started = 0;

    function automatic void look(input int addr, input bit used, input bit late,
                                 output bit st, output int fw, output bit fl);
        int best;
        int idx;
        best = 1000;
        idx  = -1;
        st = 0; fw = 0; fl = 0;
        for (int i = 0; i < q_reg.size(); i++) begin
            if (q_reg[i] == addr && q_adv[i] < best) begin
                best = q_adv[i];
                idx  = i;
            end
        end
        if (used && addr != 0 && idx >= 0) begin
            if (q_adv[idx] + (late ? 1 : 0) < q_lat[idx]) st = 1;
            else begin
                fw = q_adv[idx];
                fl = late && (q_adv[idx] < q_lat[idx]);
            end
        end
    endfunction

    function automatic void expect_out(output bit st, output int fa, output int fb, output bit fbl);
        bit sa, sb, dummy;
        look(int'(rs_addr), rs_used, 1'b0, sa, fa, dummy);
        look(int'(rt_addr), rt_used, rt_late, sb, fb, fbl);
        st = id_valid && (sa || sb);
        if (rst) begin
            st = 0; fa = 0; fb = 0; fbl = 0;
        end
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Advance the model on each clock edge
    always @(posedge clk) begin
        bit st, fbl;
        int fa, fb;
        int l;
        started <= 1;
        if (rst) begin
            q_reg.delete(); q_lat.delete(); q_adv.delete();
            m_cnt = 0;
        end else if (en) begin
            expect_out(st, fa, fb, fbl);
            if (st && m_cnt < (1 << CW) - 1) m_cnt++;
            for (int i = q_reg.size() - 1; i >= 0; i--) begin
                q_adv[i] = q_adv[i] + 1;
                if (q_adv[i] > FWD_DEPTH) begin
                    q_reg.delete(i); q_lat.delete(i); q_adv.delete(i);
                end
            end
            if (id_valid && !st && dst_wen && dst_addr != 0) begin
                l = int'(dst_lat);
                if (l < 1) l = 1;
                if (l > MAX_LAT) l = MAX_LAT;
                q_reg.push_back(int'(dst_addr));
                q_lat.push_back(l);
                q_adv.push_back(1);
            end
        end
    end

    // Compare every DUT output against the model mid-cycle
    always @(negedge clk) begin
        bit st, fbl;
        int fa, fb;
        if (started) begin
            expect_out(st, fa, fb, fbl);
            chk("cyc_stall", int'(stall), int'(st));
            chk("cyc_fwd_a", int'(fwd_a), fa);
            chk("cyc_fwd_b", int'(fwd_b), fb);
            chk("cyc_fwd_b_late", int'(fwd_b_late), int'(fbl));
            chk("cyc_stall_count", int'(stall_count), m_cnt);
        end
    end

    task automatic set_in(input bit v, input int rs, input bit rsu, input int rt, input bit rtu,
                          input bit late, input int dst, input bit wen, input int lat);
        id_valid = v;
        rs_addr  = AW'(rs);
        rs_used  = rsu;
        rt_addr  = AW'(rt);
        rt_used  = rtu;
        rt_late  = late;
        dst_addr = AW'(dst);
        dst_wen  = wen;
        dst_lat  = LW'(lat);
        #2;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) tick();
    endtask

    initial begin
        rst = 1; en = 1;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        chk("reset_stall_count", int'(stall_count), 0);
        chk("reset_stall", int'(stall), 0);
        rst = 0;
        tick();

        // ALU producer forwarded from EXE, then MEM, then regfile
        set_in(1, 0, 0, 0, 0, 0, 3, 1, LAT_ALU);
        chk("alu_issue_stall", int'(stall), 0);
        tick();
        set_in(1, 3, 1, 0, 0, 0, 0, 0, 0);
        chk("alu_r1_stall", int'(stall), 0);
        chk("alu_r1_fwd_a", int'(fwd_a), FWD_EXE);
        tick();
        chk("alu_r2_fwd_a", int'(fwd_a), FWD_MEM);
        tick();
        chk("alu_r3_fwd_a", int'(fwd_a), FWD_RF);
        tick();
        flush();

        // Load-use: one stall then forward from MEM
        set_in(1, 0, 0, 0, 0, 0, 4, 1, LAT_LOAD);
        tick();
        set_in(1, 4, 1, 0, 0, 0, 8, 1, LAT_ALU);
        chk("lu_stall", int'(stall), 1);
        tick();
        chk("lu_stall_after", int'(stall), 0);
        chk("lu_fwd_a", int'(fwd_a), 2);
        tick();
        chk("lu_stall_count", int'(stall_count), 1);
        flush();

        // Load feeding store data: late path avoids the stall
        set_in(1, 0, 0, 0, 0, 0, 5, 1, LAT_LOAD);
        tick();
        set_in(1, 0, 1, 5, 1, 1, 0, 0, 0);
        chk("st_stall", int'(stall), 0);
        chk("st_fwd_b", int'(fwd_b), 1);
        chk("st_fwd_b_late", int'(fwd_b_late), 1);
        tick();
        flush();

        // Long-latency producer beyond the taps: stall until retired, then regfile
        set_in(1, 0, 0, 0, 0, 0, 6, 1, LAT_MULDIV);
        tick();
        set_in(1, 6, 1, 0, 0, 0, 0, 0, 0);
        chk("mul_stall1", int'(stall), 1);
        tick();
        chk("mul_stall2", int'(stall), 1);
        tick();
        chk("mul_stall3", int'(stall), 0);
        chk("mul_fwd_a", int'(fwd_a), 0);
        tick();
        chk("mul_stall_count", int'(stall_count), 3);
        flush();

        // WAW: the later load owns $7
        set_in(1, 0, 0, 0, 0, 0, 7, 1, LAT_ALU);
        tick();
        set_in(1, 0, 0, 0, 0, 0, 7, 1, LAT_LOAD);
        tick();
        set_in(1, 7, 1, 0, 0, 0, 0, 0, 0);
        chk("waw_stall", int'(stall), 1);
        tick();
        chk("waw_stall_after", int'(stall), 0);
        chk("waw_fwd_a", int'(fwd_a), 2);
        tick();
        flush();

        // Same register on both operands, only rt is late
        set_in(1, 0, 0, 0, 0, 0, 12, 1, LAT_LOAD);
        tick();
        set_in(1, 12, 1, 12, 1, 1, 0, 0, 0);
        chk("same_stall", int'(stall), 1);
        chk("same_fwd_b", int'(fwd_b), 1);
        chk("same_fwd_b_late", int'(fwd_b_late), 1);
        tick();
        chk("same_fwd_a", int'(fwd_a), 2);
        chk("same_fwd_b2", int'(fwd_b), 2);
        chk("same_fwd_b_late2", int'(fwd_b_late), 0);
        tick();
        flush();

        // Freeze for three cycles mid-hazard
        set_in(1, 0, 0, 0, 0, 0, 10, 1, LAT_MULDIV);
        tick();
        set_in(1, 10, 1, 0, 0, 0, 0, 0, 0);
        chk("frz_stall0", int'(stall), 1);
        en = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("frz_stall", int'(stall), 1);
            chk("frz_count", int'(stall_count), 5);
        end
        en = 1;
        tick();
        chk("frz_stall_resume", int'(stall), 1);
        tick();
        chk("frz_stall_done", int'(stall), 0);
        chk("frz_fwd_a", int'(fwd_a), 0);
        chk("frz_count_end", int'(stall_count), 7);
        tick();
        flush();

        // Writes to $0 are never tracked
        set_in(1, 0, 0, 0, 0, 0, 0, 1, LAT_MULDIV);
        tick();
        set_in(1, 0, 1, 0, 1, 0, 0, 0, 0);
        chk("zero_stall", int'(stall), 0);
        chk("zero_fwd_a", int'(fwd_a), 0);
        tick();
        flush();

        // Zero latency behaves as an ALU op
        set_in(1, 0, 0, 0, 0, 0, 13, 1, 0);
        tick();
        set_in(1, 13, 1, 0, 0, 0, 0, 0, 0);
        chk("lat0_stall", int'(stall), 0);
        chk("lat0_fwd_a", int'(fwd_a), 1);
        tick();
        flush();

        // Reset in the middle of a hazard
        set_in(1, 0, 0, 0, 0, 0, 11, 1, LAT_LOAD);
        tick();
        set_in(1, 11, 1, 0, 0, 0, 0, 0, 0);
        chk("rst_pre_stall", int'(stall), 1);
        rst = 1;
        #1;
        chk("rst_stall", int'(stall), 0);
        tick();
        chk("rst_count", int'(stall_count), 0);
        rst = 0;
        #1;
        chk("rst_post_stall", int'(stall), 0);
        chk("rst_post_fwd_a", int'(fwd_a), 0);
        tick();
        flush();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
